motion_update_broadcaster: RTL

//  Drives the motion-update broadcast bus consumed by every Pos_Cache_X_Y_Z. Sweeps all cells, reads each old position

---
 rtl/motion_update_broadcaster.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/motion_update_broadcaster.sv
// Sweeps every cell, adds displacement to position, wraps the cell coordinate periodically and broadcasts the result.
// Optional MU_BCAST_STATS_EN adds out_migrate_count (valids whose destination differs from the source cell).
module motion_update_broadcaster #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDR_WIDTH    = 8,
    parameter int CELL_ID_WIDTH = 4,
    parameter int CELL_NUM_X    = 4,
    parameter int CELL_NUM_Y    = 4,
    parameter int CELL_NUM_Z    = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    output logic [3*CELL_ID_WIDTH-1:0]   out_rd_cell,
    output logic [ADDR_WIDTH-1:0]        out_rd_address,
    output logic                         out_rden,
    input  logic [3*DATA_WIDTH-1:0]      in_pos,
    input  logic [3*DATA_WIDTH-1:0]      in_disp,
    output logic                         out_motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]      out_data,
    output logic [3*CELL_ID_WIDTH-1:0]   out_data_dst_cell,
    output logic                         out_data_valid,
`ifdef MU_BCAST_STATS_EN
    output logic [15:0]                  out_migrate_count,
`endif
    output logic                         out_done
);

    localparam int DW = DATA_WIDTH;
    localparam int AW = ADDR_WIDTH;
    localparam int CW = CELL_ID_WIDTH;

    localparam logic [CW-1:0] NX  = CW'(CELL_NUM_X);
    localparam logic [CW-1:0] NY  = CW'(CELL_NUM_Y);
    localparam logic [CW-1:0] NZ  = CW'(CELL_NUM_Z);
    localparam logic [CW-1:0] ONE = CW'(1);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] OPEN     = 3'd1;
    localparam logic [2:0] RD_CNT   = 3'd2;
    localparam logic [2:0] WAIT_CNT = 3'd3;
    localparam logic [2:0] STREAM   = 3'd4;
    localparam logic [2:0] CLOSE    = 3'd5;
    localparam logic [2:0] DRAIN    = 3'd6;
    localparam logic [2:0] DONE     = 3'd7;

    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cx_q, cx_d, cy_q, cy_d, cz_q, cz_d;
    logic [AW-1:0]      count_q, count_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [1:0]         drain_q, drain_d;
    logic               enable_q, enable_d;
    logic               adv;
    logic               last_z, last_y, last_x, last_cell;

    // vld_q[1]: read data present on in_pos/in_disp; vld_q[2]: registered result on the bus
    logic [2:1]         vld_q;
    logic [3*CW-1:0]    src1_q;
    logic [3*DW-1:0]    data_q;
    logic [3*CW-1:0]    dst_q;

    logic [DW-1:0]      new_x, new_y, new_z;
    logic [3*CW-1:0]    new_dst;

    // Sum with periodic wrap of the cell field; fraction bits pass through unchanged.
    function automatic logic [DW-1:0] wrap_comp(input logic [DW-1:0] p,
                                                input logic [DW-1:0] d,
                                                input logic [CW-1:0] n);
        logic [DW-1:0] s;
        logic [CW-1:0] c;
        s = p + d;
        c = s[DW-1 -: CW];
        if (c == '0)
            s[DW-1 -: CW] = n;
        else if (c == n + ONE)
            s[DW-1 -: CW] = ONE;
        return s;
    endfunction

    assign last_z    = (cz_q == NZ);
    assign last_y    = (cy_q == NY);
    assign last_x    = (cx_q == NX);
    assign last_cell = last_x & last_y & last_z;

    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        cz_d     = cz_q;
        count_d  = count_q;
        addr_d   = addr_q;
        drain_d  = drain_q;
        enable_d = enable_q;
        adv      = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = OPEN;
                    enable_d = 1'b1;
                end
            end
            OPEN:   state_d = RD_CNT;
            RD_CNT: state_d = WAIT_CNT;
            WAIT_CNT: begin
                count_d = in_pos[AW-1:0];
                if (in_pos[AW-1:0] == '0) begin
                    adv = 1'b1;
                end else begin
                    state_d = STREAM;
                    addr_d  = AW'(1);
                end
            end
            STREAM: begin
                if (addr_q == count_q)
                    adv = 1'b1;
                else
                    addr_d = addr_q + AW'(1);
            end
            CLOSE: begin
                // hold the frame open until the last result has been on the bus for a cycle
                if (vld_q == '0) begin
                    state_d  = DRAIN;
                    enable_d = 1'b0;
                    drain_d  = '0;
                end
            end
            DRAIN: begin
                if (drain_q == 2'd2)
                    state_d = DONE;
                else
                    drain_d = drain_q + 2'd1;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (adv) begin
            if (last_cell) begin
                state_d = CLOSE;
                cx_d    = ONE;
                cy_d    = ONE;
                cz_d    = ONE;
            end else begin
                state_d = RD_CNT;
                if (!last_z) begin
                    cz_d = cz_q + ONE;
                end else begin
                    cz_d = ONE;
                    if (!last_y) begin
                        cy_d = cy_q + ONE;
                    end else begin
                        cy_d = ONE;
                        cx_d = cx_q + ONE;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cx_q     <= ONE;
            cy_q     <= ONE;
            cz_q     <= ONE;
            count_q  <= '0;
            addr_q   <= '0;
            drain_q  <= '0;
            enable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            cz_q     <= cz_d;
            count_q  <= count_d;
            addr_q   <= addr_d;
            drain_q  <= drain_d;
            enable_q <= enable_d;
        end
    end

    assign new_x   = wrap_comp(in_pos[DW-1:0],      in_disp[DW-1:0],      NX);
    assign new_y   = wrap_comp(in_pos[2*DW-1:DW],   in_disp[2*DW-1:DW],   NY);
    assign new_z   = wrap_comp(in_pos[3*DW-1:2*DW], in_disp[3*DW-1:2*DW], NZ);
    assign new_dst = {new_x[DW-1 -: CW], new_y[DW-1 -: CW], new_z[DW-1 -: CW]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q  <= '0;
            src1_q <= '0;
            data_q <= '0;
            dst_q  <= '0;
        end else begin
            vld_q[1] <= (state_q == STREAM);
            vld_q[2] <= vld_q[1];
            src1_q   <= {cx_q, cy_q, cz_q};
            if (vld_q[1]) begin
                data_q <= {new_z, new_y, new_x};
                dst_q  <= new_dst;
            end
        end
    end

`ifdef MU_BCAST_STATS_EN
    logic [15:0] mig_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            mig_q <= '0;
        else if (state_q == IDLE && start)
            mig_q <= '0;
        else if (vld_q[1] && new_dst != src1_q && mig_q != 16'hFFFF)
            mig_q <= mig_q + 16'd1;
    end

    assign out_migrate_count = mig_q;
`endif

    assign out_rden                 = (state_q == RD_CNT) || (state_q == STREAM);
    assign out_rd_address           = (state_q == STREAM) ? addr_q : '0;
    assign out_rd_cell              = out_rden ? {cx_q, cy_q, cz_q} : '0;
    assign out_motion_update_enable = enable_q;
    assign out_data                 = data_q;
    assign out_data_dst_cell        = dst_q;
    assign out_data_valid           = vld_q[2];
    assign out_done                 = (state_q == DONE);

endmodule
